// File: rtl/image_pkg.sv
// Shared image-path definitions: reader FSM states, pixel width and the gray weighting
// used by both the loader-side and reader-side grayscale paths.
package image_pkg;

    localparam int PIXEL_W = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } reader_state_t;

    // g = (R + 2G + B) >> 2 on a 10-bit sum, so 4*255 cannot overflow.
    function automatic logic [7:0] gray8(input logic [PIXEL_W-1:0] pixel);
        logic [9:0] sum;
        sum = {2'b00, pixel[23:16]} + {1'b0, pixel[15:8], 1'b0} + {2'b00, pixel[7:0]};
        return sum[9:2];
    endfunction

endpackage

// File: rtl/rd_skid_buffer.sv
// One-entry hold register in front of the output FIFO: a BRAM return that meets a full
// FIFO is parked here and written ahead of any new read once the FIFO has room.
module rd_skid_buffer
    import image_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [PIXEL_W-1:0] in_data,
    input  logic               out_full,
    output logic               out_wr_en,
    output logic [PIXEL_W-1:0] out_din,
    output logic               can_accept
);

    logic               r_hold_valid;
    logic [PIXEL_W-1:0] r_hold_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
        end else if (in_valid && out_full) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= in_data;
        end else if (r_hold_valid && !out_full) begin
            r_hold_valid <= 1'b0;
        end
    end

    // in_valid and r_hold_valid are never high together: a new read is only issued when
    // the hold is empty and the FIFO is not full.
    assign out_wr_en  = !out_full && (r_hold_valid || in_valid);
    assign can_accept = !r_hold_valid && !out_full;

    always_comb begin
        out_din = '0;
        if (out_wr_en) begin
            out_din = r_hold_valid ? r_hold_data : in_data;
        end
    end

endmodule

// File: rtl/bram_image_reader.sv
// Streams the stored image from BRAM in raster order into the output FIFO with backpressure.
// Define IMAGE_READER_GRAY_EN to write {g,g,g} gray pixels instead of the raw BRAM word.
module bram_image_reader
    import image_pkg::*;
#(
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 720,
    parameter int IMAGE_SIZE = WIDTH * HEIGHT
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    output logic [$clog2(IMAGE_SIZE)-1:0] bram_rd_addr,
    output logic                          bram_rd_en,
    input  logic [PIXEL_W-1:0]            bram_rd_data,
    input  logic                          out_full,
    output logic                          out_wr_en,
    output logic [PIXEL_W-1:0]            out_din,
    output logic                          busy,
    output logic                          done,
    output logic [1:0]                    dbg_state
);

    localparam int ADDR_W = $clog2(IMAGE_SIZE);
    localparam int XW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    reader_state_t      r_state;
    logic [XW-1:0]      r_x;
    logic [YW-1:0]      r_y;
    logic               r_rd_pending;

    logic               w_can_accept;
    logic               w_issue;
    logic               w_x_last;
    logic               w_last;
    logic               w_skid_wr;
    logic [PIXEL_W-1:0] w_skid_din;

    assign w_issue  = (r_state == READ) && w_can_accept;
    assign w_x_last = (r_x == XW'(WIDTH - 1));
    assign w_last   = w_x_last && (r_y == YW'(HEIGHT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_rd_pending <= 1'b0;
        end else begin
            r_rd_pending <= w_issue;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= READ;
                        r_x     <= '0;
                        r_y     <= '0;
                    end
                end
                READ: begin
                    if (w_issue) begin
                        // Counters return to 0 on the final issue so the address idles at 0.
                        if (w_last) begin
                            r_state <= DRAIN;
                            r_x     <= '0;
                            r_y     <= '0;
                        end else if (w_x_last) begin
                            r_x <= '0;
                            r_y <= r_y + YW'(1);
                        end else begin
                            r_x <= r_x + XW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (w_skid_wr) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_x     <= '0;
                    r_y     <= '0;
                end
            endcase
        end
    end

    rd_skid_buffer u_skid (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (r_rd_pending),
        .in_data    (bram_rd_data),
        .out_full   (out_full),
        .out_wr_en  (w_skid_wr),
        .out_din    (w_skid_din),
        .can_accept (w_can_accept)
    );

    assign bram_rd_en   = w_issue;
    assign bram_rd_addr = ADDR_W'(r_y) * ADDR_W'(WIDTH) + ADDR_W'(r_x);
    assign out_wr_en    = w_skid_wr;
    // Only the last pixel can still be in flight once DRAIN is entered.
    assign done         = (r_state == DRAIN) && w_skid_wr;
    assign busy         = (r_state == READ) || (r_state == DRAIN);
    assign dbg_state    = r_state;

`ifdef IMAGE_READER_GRAY_EN
    assign out_din = w_skid_wr ? {3{gray8(w_skid_din)}} : '0;
`else
    assign out_din = w_skid_din;
`endif

endmodule

// File: tb/tb_bram_image_reader.sv
// Bench for bram_image_reader on a 4x2 image: a frame-level model (expected pixel queue,
// expected address sequence, busy/done from frame boundaries) checked every cycle.
module tb_bram_image_reader;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int N  = W * H;
    localparam int AW = $clog2(N);

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] bram_rd_addr;
    logic          bram_rd_en;
    logic [23:0]   bram_rd_data = '0;
    logic          out_full;
    logic          out_wr_en;
    logic [23:0]   out_din;
    logic          busy;
    logic          done;
    logic [1:0]    dbg_state;

    always #5 clock = ~clock;

    bram_image_reader #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .bram_rd_addr (bram_rd_addr),
        .bram_rd_en   (bram_rd_en),
        .bram_rd_data (bram_rd_data),
        .out_full     (out_full),
        .out_wr_en    (out_wr_en),
        .out_din      (out_din),
        .busy         (busy),
        .done         (done),
        .dbg_state    (dbg_state)
    );

    // BRAM with registered read data, 1-cycle latency.
    logic [23:0] mem [N];
    always @(posedge clock) if (bram_rd_en) bram_rd_data <= mem[bram_rd_addr];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [23:0] expect_pixel(input logic [23:0] p);
`ifdef IMAGE_READER_GRAY_EN
        int s;
        logic [7:0] g;
        s = int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0]);
        g = 8'(s / 4);
        return {g, g, g};
`else
        return p;
`endif
    endfunction

    // Frame-level model state.
    bit          m_busy = 1'b0;
    logic [23:0] exp_q[$];
    int          m_issued = 0;
    int          m_frame_writes = 0;
    int          wr_cyc_q[$];
    logic [23:0] wr_val_q[$];
    int          done_cyc_q[$];
    logic [23:0] m_exp;
    bit          m_last;

    always @(negedge clock) begin
        if (reset) begin
            check("rst_wr_en", 32'(out_wr_en), 0);
            m_busy = 1'b0;
            exp_q.delete();
            m_issued = 0;
            m_frame_writes = 0;
        end else begin
            m_last = 1'b0;
            check("busy", 32'(busy), 32'(m_busy));
            if (bram_rd_en) begin
                check("rd_en_vs_full", 32'(out_full), 0);
                check("rd_in_frame", 32'(m_busy && m_issued < N), 1);
                check("rd_addr", 32'(bram_rd_addr), 32'(m_issued));
                m_issued++;
            end
            if (out_wr_en) begin
                check("wr_vs_full", 32'(out_full), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(out_wr_en), 0);
                end else begin
                    m_exp = exp_q.pop_front();
                    check("out_din", 32'(out_din), 32'(m_exp));
                    wr_cyc_q.push_back(cyc);
                    wr_val_q.push_back(out_din);
                    m_frame_writes++;
                    m_last = m_busy && (exp_q.size() == 0);
                end
            end else begin
                check("idle_din", 32'(out_din), 0);
            end
            check("done", 32'(done), 32'(m_last));
            if (m_last) begin
                check("frame_writes", 32'(m_frame_writes), N);
                check("frame_reads", 32'(m_issued), N);
                done_cyc_q.push_back(cyc);
                m_busy = 1'b0;
            end else if (!m_busy && start) begin
                m_busy = 1'b1;
                m_issued = 0;
                m_frame_writes = 0;
                exp_q.delete();
                for (int i = 0; i < N; i++) exp_q.push_back(expect_pixel(mem[i]));
            end
        end
    end

    // out_full driver: 0 = low, 1 = toggle, 2 = random, 3 = driven by the stimulus.
    int full_mode = 0;
    always @(posedge clock) begin
        #1;
        case (full_mode)
            0:       out_full = 1'b0;
            1:       out_full = ~out_full;
            2:       out_full = ($urandom_range(0, 99) < 40);
            default: ;
        endcase
    end

    task automatic pulse_start(output int s);
        @(posedge clock); #1;
        start = 1'b1;
        s = cyc;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_cycle(input int target);
        while (cyc < target) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (m_busy && k < budget) begin
            @(posedge clock); #1;
            k++;
        end
        check({name, "_completes"}, 32'(m_busy), 0);
    endtask

    task automatic clear_logs();
        wr_cyc_q.delete();
        wr_val_q.delete();
        done_cyc_q.delete();
    endtask

    task automatic ramp_mem();
        for (int i = 0; i < N; i++) mem[i] = 24'(i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int s;
    logic [23:0] lit7;

    initial begin
`ifdef IMAGE_READER_GRAY_EN
        lit7 = 24'h010101;
`else
        lit7 = 24'h000007;
`endif
        reset = 1'b1;
        start = 1'b0;
        out_full = 1'b0;
        ramp_mem();
        repeat (3) @(posedge clock);
        #1;
        check("reset_rd_en", 32'(bram_rd_en), 0);
        check("reset_addr", 32'(bram_rd_addr), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_din", 32'(out_din), 0);
        @(negedge clock); #1;
        reset = 1'b0;

        // 1: unthrottled frame
        full_mode = 0;
        clear_logs();
        pulse_start(s);
        wait_idle(50, "t1");
        check("t1_writes", 32'(wr_val_q.size()), 8);
        check("t1_first_latency", 32'(wr_cyc_q[0] - s), 2);
        check("t1_last_latency", 32'(wr_cyc_q[7] - s), 9);
        check("t1_done_cycle", 32'(done_cyc_q[0] - s), 9);
        check("t1_pix0", 32'(wr_val_q[0]), 0);
        check("t1_pix7", 32'(wr_val_q[7]), 32'(lit7));

        // 2: full for 3 cycles starting when pixel 2 returns
        full_mode = 3;
        out_full = 1'b0;
        clear_logs();
        pulse_start(s);
        wait_cycle(s + 4);
        out_full = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
        end
        out_full = 1'b0;
        wait_idle(50, "t2");
        check("t2_writes", 32'(wr_val_q.size()), 8);
        check("t2_pix2_cycle", 32'(wr_cyc_q[2] - s), 7);
        check("t2_pix2", 32'(wr_val_q[2]), 32'(expect_pixel(24'd2)));
        check("t2_done_cycle", 32'(done_cyc_q[0] - s), 13);

        // 3: full toggling every cycle
        full_mode = 1;
        clear_logs();
        pulse_start(s);
        wait_idle(100, "t3");
        check("t3_writes", 32'(wr_val_q.size()), 8);

        // 4: asynchronous reset after pixel 3, then a clean frame
        full_mode = 0;
        clear_logs();
        pulse_start(s);
        wait_cycle(s + 6);
        check("t4_written_before_reset", 32'(wr_val_q.size()), 4);
        reset = 1'b1;
        #1;
        check("t4_rst_rd_en", 32'(bram_rd_en), 0);
        check("t4_rst_wr_en", 32'(out_wr_en), 0);
        check("t4_rst_din", 32'(out_din), 0);
        check("t4_rst_busy", 32'(busy), 0);
        check("t4_rst_addr", 32'(bram_rd_addr), 0);
        @(negedge clock); #1;
        reset = 1'b0;
        clear_logs();
        pulse_start(s);
        wait_idle(50, "t4");
        check("t4_writes", 32'(wr_val_q.size()), 8);
        check("t4_pix0", 32'(wr_val_q[0]), 0);

        // 5: start mid-frame and on the done cycle are ignored
        clear_logs();
        pulse_start(s);
        wait_cycle(s + 4);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_cycle(s + 9);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
        end
        check("t5_busy_after", 32'(busy), 0);
        check("t5_state_idle", 32'(dbg_state), 0);
        check("t5_done_count", 32'(done_cyc_q.size()), 1);
        check("t5_writes", 32'(wr_val_q.size()), 8);
        clear_logs();
        pulse_start(s);
        wait_idle(50, "t5b");
        check("t5b_writes", 32'(wr_val_q.size()), 8);

        // 6: gray conversion pin
        mem[0] = 24'h102030;
        clear_logs();
        pulse_start(s);
        wait_idle(50, "t6");
`ifdef IMAGE_READER_GRAY_EN
        check("t6_pix0", 32'(wr_val_q[0]), 32'h202020);
`else
        check("t6_pix0", 32'(wr_val_q[0]), 32'h102030);
`endif

        // Random images under random backpressure
        full_mode = 2;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++) mem[i] = 24'($urandom);
            clear_logs();
            pulse_start(s);
            wait_idle(300, "rand");
            check("rand_writes", 32'(wr_val_q.size()), 8);
            repeat ($urandom_range(0, 3)) @(posedge clock);
            #1;
        end

        full_mode = 0;
        repeat (2) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bram_image_reader.md
Name: bram_image_reader

Overview:
Streams a stored image out of the image BRAM in raster order into an output FIFO. It is the read-side counterpart of the image loader. On a start pulse it walks addresses 0..IMAGE_SIZE-1, absorbs the 1-cycle BRAM read latency, and honours FIFO backpressure (out_full) through a one-entry hold register, so no pixel is lost or duplicated. It sits between the processed-image BRAM and the output FIFO feeding the host/UART path.

Parameters:
WIDTH, 1280, image width in pixels
HEIGHT, 720, image height in pixels
IMAGE_SIZE, WIDTH*HEIGHT, total pixels; sets BRAM address width $clog2(IMAGE_SIZE)

Ports:
clock  input  1  system clock
reset  input  1  reset, asynchronous, active-high
start  input  1  one-cycle pulse; begin a frame readout (ignored while busy)
bram_rd_addr  output  $clog2(IMAGE_SIZE)  BRAM read address
bram_rd_en  output  1  BRAM read strobe; data valid on bram_rd_data the next cycle
bram_rd_data  input  24  BRAM read data, registered, 1-cycle latency
out_full  input  1  output FIFO full
out_wr_en  output  1  output FIFO write strobe
out_din  output  24  pixel written to FIFO
busy  output  1  high from the cycle after an accepted start through the done cycle
done  output  1  one-cycle pulse on the cycle the final pixel is written

Behaviour:
- Clocking and reset: reset is asynchronous, active-high; clock is clock. On reset: state=IDLE, x=y=0, rd_pending=0, hold_valid=0, hold_data=0. Outputs are bram_rd_en=0, bram_rd_addr=0, out_wr_en=0, out_din=0, busy=0, done=0. Reset mid-frame drops in-flight data; no partial done.
- Counters: x of width $clog2(WIDTH) and y of width $clog2(HEIGHT). bram_rd_addr = y*WIDTH + x, computed at full address width. Wrap rule: x==WIDTH-1 sets x=0 and y=y+1.
- States:
  - IDLE: start=1 moves to READ, x=y=0.
  - READ: issue a read when out_full==0 and hold_valid==0. An issue drives bram_rd_en=1 and advances x/y. When (x,y)==(WIDTH-1,HEIGHT-1) is issued, move to DRAIN.
  - DRAIN: issue no reads. When the last pixel is written to the FIFO, pulse done=1 and move to IDLE.
- rd_pending is set to 1 the cycle after an issue and is 0 otherwise.
- Return path (rd_pending=1):
  - If hold_valid=0 and out_full=0: out_wr_en=1 and out_din=bram_rd_data in the same cycle.
  - If out_full=1: capture bram_rd_data into hold_data and set hold_valid=1.
- Hold drain: while hold_valid=1 and out_full=0, out_wr_en=1, out_din=hold_data and hold_valid clears. No read issues in that cycle.
- The issue rule guarantees rd_pending and hold_valid are never 1 together. A return can never collide with a full hold.
- Throughput is 1 pixel/clock while out_full=0. First write happens 1 cycle after the first issue, i.e. 2 cycles after start.
- out_wr_en is never asserted while out_full=1.
- out_din=0 when out_wr_en=0.
- start while busy is ignored. start in the same cycle as done is ignored; the next start is accepted from IDLE.
- The default state branch returns to IDLE with outputs deasserted.

Optional Feature:
Macro IMAGE_READER_GRAY_EN.
- Defined: each written pixel is converted to g=(R+2G+B)>>2, using a 10-bit intermediate and keeping the 8-bit result. out_din = {g,g,g}. The conversion is combinational on the write path and latency is unchanged.
- Not defined: out_din is the raw 24-bit BRAM word.

Decomposition:
- Shared package image_pkg holds:
  - reader_state_t enum {IDLE, READ, DRAIN}, 2 bits
  - PIXEL_W=24 constant
  - the gray-weighting function, shared with the loader-side grayscale blocks
- One natural sub-module, rd_skid_buffer: the one-entry hold register plus FIFO-write mux, with in_valid/in_data/out_full in and out_wr_en/out_din/can_accept out.

Test Plan:
1. WIDTH=4, HEIGHT=2, BRAM[i]=i, out_full=0, start pulse -> 8 consecutive out_wr_en cycles, out_din=0..7, first write 2 cycles after start, done coincident with pixel 7, busy low the next cycle.
2. Same image with out_full=1 for 3 cycles starting on the cycle pixel 2 returns -> pixel 2 held, then written first once full drops, sequence still 0..7 with no duplicates, bram_rd_en=0 while full.
3. out_full toggling every cycle for the whole frame -> exactly 8 writes in order, out_wr_en never high with out_full high.
4. Reset asserted after pixel 3 is written -> all outputs 0 immediately (asynchronous). A new start then yields 0..7 from address 0.
5. start re-pulsed mid-frame and on the done cycle -> ignored, with exactly 8 writes per accepted start.
6. IMAGE_READER_GRAY_EN defined, BRAM[0]=24'h102030 -> out_din=24'h202020 (R=0x10, G=0x20, B=0x30: (0x10+0x40+0x30)>>2=0x20).
